// File: rtl/counter_preset_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : counter_preset_sequencer_if
// Purpose  : valid/ready preset channel into the counter preset sequencer
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface counter_preset_sequencer_if #(
  parameter int WIDTH = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface
`default_nettype wire

// File: rtl/counter_preset_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : counter_preset_sequencer
// Purpose  : buffers preset values in a small FIFO and reloads a downstream
//            loadable counter with the next preset on each terminal match
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module counter_preset_sequencer #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  counter_preset_sequencer_if.slave in_bus,
  input  logic                   flush,
  input  logic                   start,
  input  logic                   stop,
  input  logic [WIDTH-1:0]       term_value,
  input  logic [WIDTH-1:0]       count_in,
  output logic                   load,
  output logic [WIDTH-1:0]       data_out,
  output logic [PTR_W:0]         level,
  output logic                   busy,
  output logic                   underrun
);

  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRST  = 3'd1,
    RUN    = 3'd2,
    RELOAD = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] last_preset;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             act;
  logic             have_head;
  logic [WIDTH-1:0] head;

  // Full is taken from registered occupancy only, so a same-cycle pop never
  // opens a slot for a push.
  assign full      = (level == FULL_LEVEL);
  assign empty     = (level == '0);
  assign head      = mem[rd_ptr];
  assign in_bus.in_ready = !full;

  // A reload is issued from FIRST/RELOAD unless stop cancels it; a flush in the
  // same cycle makes the FIFO look empty so the reload falls back to last_preset.
  assign act       = ((state == FIRST) || (state == RELOAD)) && !stop;
  assign have_head = !empty && !flush;
  assign pop       = act && have_head;
  assign push      = in_bus.in_valid && !full && !flush;
  assign busy      = (state != IDLE);

  // Preset storage: written on an accepted push, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_bus.in_data;
    end
  end

  // FIFO pointers and occupancy; flush empties the buffer outright
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level <= level + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // Sequencing FSM with registered load/data_out/underrun
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      load        <= 1'b0;
      data_out    <= '0;
      last_preset <= '0;
      underrun    <= 1'b0;
    end else begin
      load <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop && !empty) begin
            state <= FIRST;
          end
        end
        FIRST, RELOAD: begin
          if (act) begin
            load <= 1'b1;
            if (have_head) begin
              data_out    <= head;
              last_preset <= head;
            end else begin
              data_out <= last_preset;
              underrun <= 1'b1;
            end
            state <= HOLD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          state <= stop ? IDLE : RUN;
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
          end else if (count_in == term_value) begin
            state <= RELOAD;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
